// File: rtl/cnn_pkg.sv
// cnn_pkg: shared sizing, state encoding and helpers for the CNN image feeder.
// Feeder state constants are fixed-width localparams so legacy code can compare against them.
package cnn_pkg;

   localparam int IMG_W_DEF  = 28;
   localparam int IMG_H_DEF  = 28;
   localparam int IMG_PIXELS = IMG_W_DEF * IMG_H_DEF;
   localparam int CLASS_W    = 10;
   localparam int DATA_W     = 32;

   typedef logic [2:0] feed_state_t;

   localparam feed_state_t FILL   = 3'd0;
   localparam feed_state_t START  = 3'd1;
   localparam feed_state_t STREAM = 3'd2;
   localparam feed_state_t WAIT   = 3'd3;
   localparam feed_state_t RESULT = 3'd4;

   // Pointer width for an n-entry buffer, never narrower than one bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/feed_buffer.sv
// feed_buffer: DEPTH x DW simple dual-port RAM, synchronous write, asynchronous read.
// Contents are deliberately not reset; the host rewrites the full image after reset.
import cnn_pkg::*;

module feed_buffer #(
   parameter int DEPTH = IMG_PIXELS,
   parameter int DW    = DATA_W,
   parameter int AW    = ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/cnn_image_feeder.sv
// cnn_image_feeder: buffers one host image, starts the CNN core, streams pixels, returns classes.
// Optional macro CNN_FEED_BINARIZE_EN maps each streamed pixel to +1/-1 against THRESH.
import cnn_pkg::*;

module cnn_image_feeder #(
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int DW     = DATA_W,
   parameter int THRESH = 128
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               wr_valid,
   input  logic [DW-1:0]      wr_data,
   output logic               wr_ready,
   output logic               cnn_start,
   output logic [DW-1:0]      cnn_din,
   output logic               cnn_din_valid,
   input  logic               cnn_din_ready,
   input  logic               cnn_done,
   input  logic [CLASS_W-1:0] cnn_classes,
   output logic [CLASS_W-1:0] result_classes,
   output logic               result_valid,
   input  logic               result_ack,
   output logic               busy
);

   localparam int            N    = IMG_W * IMG_H;
   localparam int            AW   = ptr_w(N);
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   feed_state_t        state_q, state_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CLASS_W-1:0] classes_q, classes_d;
   logic               wr_en;
   logic [DW-1:0]      rd_word;
   logic [DW-1:0]      pix;

   assign wr_en = (state_q == FILL) && wr_valid;

   feed_buffer #(
      .DEPTH (N),
      .DW    (DW),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (wr_data),
      .raddr (rd_ptr_q),
      .rdata (rd_word)
   );

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      classes_d = classes_q;
      case (state_q)
         FILL: begin
            if (wr_valid) begin
               if (wr_ptr_q == LAST) begin
                  wr_ptr_d = '0;
                  state_d  = START;
               end else begin
                  wr_ptr_d = wr_ptr_q + AW'(1);
               end
            end
         end
         START: begin
            rd_ptr_d = '0;
            state_d  = STREAM;
         end
         STREAM: begin
            if (cnn_din_ready) begin
               if (rd_ptr_q == LAST) begin
                  rd_ptr_d = '0;
                  state_d  = WAIT;
               end else begin
                  rd_ptr_d = rd_ptr_q + AW'(1);
               end
            end
         end
         WAIT: begin
            if (cnn_done) begin
               classes_d = cnn_classes;
               state_d   = RESULT;
            end
         end
         RESULT: begin
            if (result_ack) begin
               state_d = FILL;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= FILL;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         classes_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         classes_q <= classes_d;
      end
   end

`ifdef CNN_FEED_BINARIZE_EN
   localparam logic signed [DW-1:0] THR = DW'(THRESH);

   // Buffer keeps raw words; only the streamed view is binarized.
   always_comb begin
      pix = ($signed(rd_word) >= THR) ? DW'(1) : '1;
   end
`else
   logic unused_thresh;

   assign unused_thresh = (THRESH != 0);

   always_comb begin
      pix = rd_word;
   end
`endif

   // Gate the read data so cnn_din is 0 outside STREAM, independent of RAM contents.
   assign cnn_din        = (state_q == STREAM) ? pix : '0;
   assign cnn_din_valid  = (state_q == STREAM);
   assign cnn_start      = (state_q == START);
   assign wr_ready       = (state_q == FILL);
   assign result_valid   = (state_q == RESULT);
   assign result_classes = classes_q;
   assign busy           = (state_q != FILL);

endmodule

// File: tb/tb_cnn_image_feeder.sv
// tb_cnn_image_feeder: directed self-checking bench for cnn_image_feeder.
// Expected pixel values come from the bench's own image table; binarized view when CNN_FEED_BINARIZE_EN is set.
module tb_cnn_image_feeder;

   localparam int IMG_W = 28;
   localparam int IMG_H = 28;
   localparam int N     = IMG_W * IMG_H;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          wr_valid = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ready;
   logic          cnn_start;
   logic [DW-1:0] cnn_din;
   logic          cnn_din_valid;
   logic          cnn_din_ready = 1'b0;
   logic          cnn_done = 1'b0;
   logic [9:0]    cnn_classes = '0;
   logic [9:0]    result_classes;
   logic          result_valid;
   logic          result_ack = 1'b0;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] img [N];

   always #5 clk = ~clk;

   cnn_image_feeder #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .DW     (DW),
      .THRESH (128)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .wr_valid       (wr_valid),
      .wr_data        (wr_data),
      .wr_ready       (wr_ready),
      .cnn_start      (cnn_start),
      .cnn_din        (cnn_din),
      .cnn_din_valid  (cnn_din_valid),
      .cnn_din_ready  (cnn_din_ready),
      .cnn_done       (cnn_done),
      .cnn_classes    (cnn_classes),
      .result_classes (result_classes),
      .result_valid   (result_valid),
      .result_ack     (result_ack),
      .busy           (busy)
   );

   function automatic logic [DW-1:0] exp_f(input logic [DW-1:0] x);
`ifdef CNN_FEED_BINARIZE_EN
      return ($signed(x) >= 128) ? 32'd1 : 32'hFFFF_FFFF;
`else
      return x;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Writes img[] with wr_valid held high; ends in the START cycle.
   task automatic write_image();
      for (int i = 0; i < N; i++) begin
         wr_valid = 1'b1;
         wr_data  = img[i];
         n_checks++;
         if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_ready px %0d: wr_ready=%b expected 1", i, wr_ready);
         end
         tick();
      end
      wr_valid = 1'b0;
      wr_data  = '0;
      n_checks++;
      if (cnn_start !== 1'b1 || wr_ready !== 1'b0 || busy !== 1'b1 || cnn_din_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL start_cycle: start=%b wr_ready=%b busy=%b valid=%b expected 1 0 1 0",
                  cnn_start, wr_ready, busy, cnn_din_valid);
      end
   endtask

   // Checks pixels first..last-1 with cnn_din_ready held high.
   task automatic stream_px(input int first, input int last);
      for (int i = first; i < last; i++) begin
         n_checks++;
         if (cnn_din_valid !== 1'b1 || cnn_start !== 1'b0 || cnn_din !== exp_f(img[i])) begin
            n_fail++;
            $display("FAIL stream_px %0d: valid=%b start=%b din=%h expected 1 0 %h",
                     i, cnn_din_valid, cnn_start, cnn_din, exp_f(img[i]));
         end
         tick();
      end
   endtask

   task automatic check_wait(input string tag);
      n_checks++;
      if (cnn_din_valid !== 1'b0 || busy !== 1'b1 || result_valid !== 1'b0 || wr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: valid=%b busy=%b rvalid=%b wr_ready=%b expected 0 1 0 0",
                  tag, cnn_din_valid, busy, result_valid, wr_ready);
      end
   endtask

   task automatic finish_result(input logic [9:0] cls);
      cnn_done    = 1'b1;
      cnn_classes = cls;
      tick();
      cnn_done    = 1'b0;
      cnn_classes = '0;
      n_checks++;
      if (result_valid !== 1'b1 || result_classes !== cls) begin
         n_fail++;
         $display("FAIL result_capture: rvalid=%b classes=%h expected 1 %h", result_valid, result_classes, cls);
      end
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      n_checks++;
      if (result_valid !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL result_release: rvalid=%b wr_ready=%b busy=%b expected 0 1 0",
                  result_valid, wr_ready, busy);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick();
      tick();
      n_checks++;
      if (cnn_start !== 1'b0 || cnn_din_valid !== 1'b0 || cnn_din !== '0 || result_valid !== 1'b0 ||
          result_classes !== '0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: start=%b valid=%b din=%h rvalid=%b cls=%h busy=%b wr_ready=%b expected 0 0 0 0 0 0 1",
                  cnn_start, cnn_din_valid, cnn_din, result_valid, result_classes, busy, wr_ready);
      end
      rstn = 1'b1;
      tick();
      n_checks++;
      if (wr_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: wr_ready=%b busy=%b expected 1 0", wr_ready, busy);
      end
   endtask

   task automatic test_fill_stream();
      for (int i = 0; i < N; i++) img[i] = DW'(i);
      write_image();
      cnn_din_ready = 1'b1;
      tick();
      stream_px(0, N);
      check_wait("stream_len_wait");
      tick();
      check_wait("wait_holds");
      finish_result(10'h155);
   endtask

   task automatic test_back_to_back();
      logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int consumed = 0;
      int c = 0;
      for (int i = 0; i < N; i++) img[i] = DW'(i * 3 + 7);
      write_image();
      cnn_din_ready = 1'b1;
      tick();
      while (consumed < N && c < 4 * N) begin
         cnn_din_ready = pat[c % 4];
         cnn_done      = (c == 5);
         cnn_classes   = (c == 5) ? 10'h3FF : 10'h000;
         wr_valid      = 1'b1;
         wr_data       = 32'hDEAD_BEEF;
         n_checks++;
         if (cnn_din_valid !== 1'b1 || cnn_din !== exp_f(img[consumed])) begin
            n_fail++;
            $display("FAIL backpressure cyc %0d: valid=%b din=%h expected 1 %h",
                     c, cnn_din_valid, cnn_din, exp_f(img[consumed]));
         end
         tick();
         if (pat[c % 4]) consumed++;
         c++;
      end
      wr_valid      = 1'b0;
      wr_data       = '0;
      cnn_done      = 1'b0;
      cnn_classes   = '0;
      cnn_din_ready = 1'b0;
      n_checks++;
      if (consumed != N) begin
         n_fail++;
         $display("FAIL backpressure_budget: consumed=%0d expected %0d", consumed, N);
      end
      check_wait("backpressure_wait");
      n_checks++;
      if (result_classes !== 10'h155) begin
         n_fail++;
         $display("FAIL done_in_stream_ignored: classes=%h expected 155", result_classes);
      end
   endtask

   task automatic test_result_ack();
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      check_wait("ack_in_wait_ignored");
      cnn_done    = 1'b1;
      cnn_classes = 10'h200;
      tick();
      cnn_done    = 1'b0;
      cnn_classes = '0;
      n_checks++;
      if (result_valid !== 1'b1 || result_classes !== 10'h200) begin
         n_fail++;
         $display("FAIL capture_200: rvalid=%b classes=%h expected 1 200", result_valid, result_classes);
      end
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (result_valid !== 1'b1 || wr_ready !== 1'b0 || result_classes !== 10'h200) begin
            n_fail++;
            $display("FAIL result_hold %0d: rvalid=%b wr_ready=%b classes=%h expected 1 0 200",
                     k, result_valid, wr_ready, result_classes);
         end
         tick();
      end
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      n_checks++;
      if (result_valid !== 1'b0 || wr_ready !== 1'b1 || busy !== 1'b0 || result_classes !== 10'h200) begin
         n_fail++;
         $display("FAIL ack_release: rvalid=%b wr_ready=%b busy=%b classes=%h expected 0 1 0 200",
                  result_valid, wr_ready, busy, result_classes);
      end
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < N; i++) img[i] = DW'(i + 5);
      write_image();
      cnn_din_ready = 1'b1;
      tick();
      stream_px(0, 400);
      rstn = 1'b0;
      #1;
      n_checks++;
      if (cnn_start !== 1'b0 || cnn_din_valid !== 1'b0 || cnn_din !== '0 || result_valid !== 1'b0 ||
          result_classes !== '0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midstream_reset: start=%b valid=%b din=%h rvalid=%b cls=%h busy=%b wr_ready=%b expected 0 0 0 0 0 0 1",
                  cnn_start, cnn_din_valid, cnn_din, result_valid, result_classes, busy, wr_ready);
      end
      cnn_din_ready = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      for (int i = 0; i < N; i++) img[i] = DW'(N - 1 - i) + 32'h0000_1000;
      write_image();
      cnn_din_ready = 1'b1;
      tick();
      stream_px(0, N);
      check_wait("fresh_image_wait");
      finish_result(10'h001);
   endtask

`ifdef CNN_FEED_BINARIZE_EN
   task automatic test_binarize();
      logic [DW-1:0] want [3] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
      for (int i = 0; i < N; i++) img[i] = '0;
      img[0] = 32'd127;
      img[1] = 32'd128;
      img[2] = -32'sd5;
      write_image();
      cnn_din_ready = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (cnn_din !== want[i]) begin
            n_fail++;
            $display("FAIL binarize px %0d: din=%h expected %h", i, cnn_din, want[i]);
         end
         tick();
      end
      stream_px(3, N);
      check_wait("binarize_wait");
      finish_result(10'h002);
   endtask
`endif

   initial begin
      test_reset();
      test_fill_stream();
      test_back_to_back();
      test_result_ack();
      test_reset_midstream();
`ifdef CNN_FEED_BINARIZE_EN
      test_binarize();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
